// File: rtl/cnn_param_pkg.sv
// rtl/cnn_param_pkg.sv - shared CNN parameter types and constants
package cnn_param_pkg;

    typedef logic signed [7:0] q17_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_e;

    localparam int BIAS_DEPTH_CONV5 = 64;

endpackage

// File: rtl/bias_stream_loader_if.sv
// rtl/bias_stream_loader_if.sv - valid/ready byte stream into the bias loader
interface bias_stream_loader_if #(
    parameter int DW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/bias_stream_loader.sv
// rtl/bias_stream_loader.sv - streams bias bytes into a register array read like a bias ROM
module bias_stream_loader
    import cnn_param_pkg::*;
#(
    parameter  int DEPTH = BIAS_DEPTH_CONV5,
    parameter  int DW    = 8,
    parameter  int AW    = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    bias_stream_loader_if.slave  s_in,
    input  logic [AW-1:0]        row,
    input  logic [AW-1:0]        col,
    output logic signed [DW-1:0] data,
    output logic                 busy,
    output logic                 loaded,
    output logic [CW-1:0]        count,
    output logic signed [15:0]   checksum
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0]    S_IDLE    = IDLE;
    localparam logic [1:0]    S_LOAD    = LOAD;
    localparam logic [1:0]    S_DONE    = DONE;
    localparam logic [AW-1:0] DEPTH_A   = AW'(DEPTH);
    localparam logic [CW-1:0] LAST_CNT  = CW'(DEPTH - 1);

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic signed [15:0]   checksum_q, checksum_d;
    logic signed [DW-1:0] mem_q [DEPTH];

    logic                 accept;
    logic [IW-1:0]        wr_idx;
    logic [IW-1:0]        rd_idx;
    logic                 rd_ok;
    logic signed [15:0]   in_sext;

    assign busy       = (state_q == S_LOAD);
    assign loaded     = (state_q == S_DONE);
    // A restart cycle is never also a data beat, so count always restarts at 0.
    assign s_in.in_ready = busy && !load_start;
    assign accept     = s_in.in_valid && s_in.in_ready;
    assign wr_idx     = count_q[IW-1:0];
    assign in_sext    = {{(16-DW){s_in.in_data[DW-1]}}, s_in.in_data};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        checksum_d = checksum_q;
        if (load_start) begin
            state_d    = S_LOAD;
            count_d    = '0;
            checksum_d = '0;
        end else if (accept) begin
            count_d    = count_q + 1'b1;
            checksum_d = checksum_q + in_sext;
            if (count_q == LAST_CNT) begin
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            checksum_q <= checksum_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept) begin
            mem_q[wr_idx] <= s_in.in_data;
        end
    end

    // Only column 0 exists; anything else reads as zero, like the ROMs.
    assign rd_ok  = (col == '0) && (row < DEPTH_A);
    assign rd_idx = row[IW-1:0];
    assign data   = rd_ok ? mem_q[rd_idx] : '0;

    assign count    = count_q;
    assign checksum = checksum_q;

endmodule

// File: tb/tb_bias_stream_loader.sv
// tb/tb_bias_stream_loader.sv - directed self-checking bench for bias_stream_loader
module tb_bias_stream_loader;

    logic               clk;
    logic               rst;
    logic               load_start;
    logic [15:0]        row;
    logic [15:0]        col;
    logic signed [7:0]  data;
    logic               busy;
    logic               loaded;
    logic [6:0]         count;
    logic signed [15:0] checksum;

    bias_stream_loader_if #(.DW(8)) s_if ();

    bias_stream_loader #(.DEPTH(64), .DW(8), .AW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .s_in       (s_if),
        .row        (row),
        .col        (col),
        .data       (data),
        .busy       (busy),
        .loaded     (loaded),
        .count      (count),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    row;
        int    col;
        int    exp;
    } rd_vec_t;

    rd_vec_t vecs [8];
    int n_checks;
    int n_fail;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_at(input int r, input int c, output int d);
        row = r[15:0];
        col = c[15:0];
        #1;
        d = int'(data);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        #1;
    endtask

    int d;
    int cyc;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{"rd_row0",      0,     0, -32};
        vecs[1] = '{"rd_row39",     39,    0, 7};
        vecs[2] = '{"rd_row63",     63,    0, 31};
        vecs[3] = '{"rd_row1",      1,     0, -31};
        vecs[4] = '{"rd_row64",     64,    0, 0};
        vecs[5] = '{"rd_col1",      3,     1, 0};
        vecs[6] = '{"rd_rowmax",    65535, 0, 0};
        vecs[7] = '{"rd_row32",     32,    0, 0};

        rst           = 1'b1;
        load_start    = 1'b0;
        s_if.in_valid = 1'b0;
        s_if.in_data  = '0;
        row           = '0;
        col           = '0;
        tick();
        tick();

        check("rst_ready",    int'(s_if.in_ready), 0);
        check("rst_busy",     int'(busy), 0);
        check("rst_loaded",   int'(loaded), 0);
        check("rst_count",    int'(count), 0);
        check("rst_checksum", int'(checksum), 0);
        for (int r = 0; r < 64; r++) begin
            read_at(r, 0, d);
            check("rst_data", d, 0);
        end

        rst = 1'b0;
        tick();

        // Valid in IDLE is dropped.
        s_if.in_valid = 1'b1;
        s_if.in_data  = 8'h7F;
        tick();
        tick();
        check("idle_count", int'(count), 0);
        check("idle_ready", int'(s_if.in_ready), 0);
        read_at(0, 0, d);
        check("idle_row0", d, 0);
        s_if.in_valid = 1'b0;

        // Full back-to-back load of i-32.
        start_load();
        check("start_busy",  int'(busy), 1);
        check("start_ready", int'(s_if.in_ready), 1);
        s_if.in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            s_if.in_data = 8'(i - 32);
            tick();
            if (i == 0) begin
                read_at(0, 0, d);
                check("wr_latency_row0", d, -32);
            end
            if (i == 62) begin
                check("beat63_count",  int'(count), 63);
                check("beat63_loaded", int'(loaded), 0);
            end
        end
        check("full_count",    int'(count), 64);
        check("full_checksum", int'(checksum), -32);
        check("full_loaded",   int'(loaded), 1);
        check("full_ready",    int'(s_if.in_ready), 0);
        check("full_busy",     int'(busy), 0);

        s_if.in_data = 8'h55;
        tick();
        check("post_full_count", int'(count), 64);
        s_if.in_valid = 1'b0;

        for (int k = 0; k < 8; k++) begin
            read_at(vecs[k].row, vecs[k].col, d);
            check(vecs[k].name, d, vecs[k].exp);
        end
        col = '0;

        // Reload from DONE with -128 everywhere.
        start_load();
        check("reload_loaded", int'(loaded), 0);
        s_if.in_valid = 1'b1;
        s_if.in_data  = 8'sh80;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (i == 31) check("reload_mid_loaded", int'(loaded), 0);
        end
        check("reload_checksum", int'(checksum), -8192);
        check("reload_loaded2", int'(loaded), 1);
        s_if.in_valid = 1'b0;

        // Restart after 10 beats of 1 with valid held.
        start_load();
        s_if.in_valid = 1'b1;
        s_if.in_data  = 8'sd1;
        for (int i = 0; i < 10; i++) tick();
        check("pre_restart_count", int'(count), 10);
        load_start   = 1'b1;
        s_if.in_data = 8'sd99;
        #1;
        check("restart_ready", int'(s_if.in_ready), 0);
        tick();
        load_start = 1'b0;
        s_if.in_valid = 1'b0;
        #1;
        check("restart_count",    int'(count), 0);
        check("restart_checksum", int'(checksum), 0);
        read_at(10, 0, d);
        check("restart_row10", d, -128);
        read_at(9, 0, d);
        check("restart_row9", d, 1);
        read_at(0, 0, d);
        check("restart_row0", d, 1);

        // Gapped valid: 64 beats of 5, valid every other cycle.
        s_if.in_data = 8'sd5;
        cyc = 0;
        while (!loaded && cyc < 200) begin
            s_if.in_valid = (cyc % 2 == 0);
            tick();
            cyc++;
        end
        s_if.in_valid = 1'b0;
        check("gap_cycles",   cyc, 127);
        check("gap_loaded",   int'(loaded), 1);
        check("gap_checksum", int'(checksum), 320);
        read_at(63, 0, d);
        check("gap_row63", d, 5);

        // Asynchronous reset mid-load.
        start_load();
        s_if.in_valid = 1'b1;
        s_if.in_data  = 8'sd7;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy",     int'(busy), 0);
        check("arst_count",    int'(count), 0);
        check("arst_checksum", int'(checksum), 0);
        check("arst_ready",    int'(s_if.in_ready), 0);
        for (int r = 0; r < 64; r++) begin
            read_at(r, 0, d);
            check("arst_data", d, 0);
        end
        s_if.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
